// File: rtl/dotmatrix_pkg.sv
// ---------------------------------------------------------------------------
// dotmatrix_pkg
//
// Definitions shared by the dot-matrix scanner, the legacy screen driver and
// the game logic that renders frames for it.
//
// Contents
//   DEF_*        default geometry (16x16 panel, 64 slots per row, 4-bit PWM)
//   phase_e      the two half-slot phases of the scan
//   row_fix()    maps a scan row to the bitmap row it displays
//   pixel_index  flat bit index of pixel (r,c) in a ROWS*COLS bitmap
//   pwm_on()     PWM threshold compare used to gate oeb
// ---------------------------------------------------------------------------
package dotmatrix_pkg;

    localparam int DEF_ROWS    = 16;
    localparam int DEF_COLS    = 16;
    localparam int DEF_TW      = 6;
    localparam int DEF_BW      = 4;
    localparam int DEF_ROW_FIX = 1;

    // Each shift slot lasts two clocks: data is set up, then strobed.
    typedef enum logic {
        PH_SETUP  = 1'b0,
        PH_STROBE = 1'b1
    } phase_e;

    // The v01 board has adjacent row pairs swapped in the wiring, so scan row
    // r must show bitmap row r^1. With an odd row count the last row has no
    // partner and is shown straight.
    function automatic int unsigned row_fix(input int unsigned r,
                                            input bit          fix,
                                            input int unsigned rows);
        if (fix && ((r ^ 32'd1) < rows)) begin
            return r ^ 32'd1;
        end
        return r;
    endfunction

    // Pixel (r,c) lives at bit r*cols+c of the flat bitmap bus.
    function automatic int unsigned pixel_index(input int unsigned r,
                                                input int unsigned c,
                                                input int unsigned cols);
        return r * cols + c;
    endfunction

    // level is the top BW bits of the slot counter; the LEDs are lit while it
    // is below the brightness setting, so brightness 0 never lights.
    function automatic logic pwm_on(input int unsigned level,
                                    input int unsigned brightness);
        return level < brightness;
    endfunction

endpackage

// File: rtl/dotmatrix_if.sv
// ---------------------------------------------------------------------------
// dotmatrix_if
//
// Bundles the bitmap bus from the game logic and the panel drive lines.
//
//   fb_in        ROWS*COLS  bitmap, pixel (r,c) = fb_in[r*COLS+c], 1 = lit
//   fb_load      1          one-cycle strobe capturing fb_in
//   brightness   BW         PWM on-time level, 0 = dark
//   rclk/rsdi    1          row shift register clock / active-low data
//   cclk/csdi    1          column shift register clock / data
//   le           1          column latch enable
//   oeb          1          panel output enable, active-low
//   frame_start  1          one-cycle pulse at each frame boundary
//
// master: the renderer side (drives the bitmap, watches frame_start)
// slave : the scanner side (accepts the bitmap, drives the panel)
// ---------------------------------------------------------------------------
interface dotmatrix_if
    import dotmatrix_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int BW   = DEF_BW
) ();

    logic [ROWS*COLS-1:0] fb_in;
    logic                 fb_load;
    logic [BW-1:0]        brightness;

    logic                 rclk;
    logic                 rsdi;
    logic                 oeb;
    logic                 csdi;
    logic                 cclk;
    logic                 le;
    logic                 frame_start;

    modport master (
        output fb_in, fb_load, brightness,
        input  rclk, rsdi, oeb, csdi, cclk, le, frame_start
    );

    modport slave (
        input  fb_in, fb_load, brightness,
        output rclk, rsdi, oeb, csdi, cclk, le, frame_start
    );

endinterface

// File: rtl/dotmatrix_framebuf.sv
// ---------------------------------------------------------------------------
// dotmatrix_framebuf
//
// Double-buffered frame store. A load goes into the pending buffer; the
// display buffer only changes at the frame swap point, so a frame is never
// torn mid-scan.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   fb_in_i        flat bitmap, pixel (r,c) = fb_in_i[r*COLS+c]
//   fb_load_i      capture fb_in_i into pending, mark it valid
//   swap_i         high in the single cycle that is the frame swap point
//   row_i          scan row being shifted out
//   row_data_o     the COLS pixels of the bitmap row shown on scan row row_i
// ---------------------------------------------------------------------------
module dotmatrix_framebuf
    import dotmatrix_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int ROW_FIX = DEF_ROW_FIX,
    localparam int RW     = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] fb_in_i,
    input  logic                 fb_load_i,
    input  logic                 swap_i,
    input  logic [RW-1:0]        row_i,
    output logic [COLS-1:0]      row_data_o
);

    // Row r of a packed [ROWS][COLS] array is bits r*COLS +: COLS, which is
    // exactly the flat bitmap layout, so loads are a plain copy.
    logic [ROWS-1:0][COLS-1:0] pend_q, pend_d;
    logic [ROWS-1:0][COLS-1:0] disp_q, disp_d;
    logic                      pend_valid_q, pend_valid_d;

    logic                      swap_now;
    logic [ROWS-1:0][COLS-1:0] frame;
    logic [RW-1:0]             drow;

    assign swap_now = swap_i && pend_valid_q;
    assign drow     = RW'(row_fix(32'(row_i), ROW_FIX != 0, ROWS));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch can be inferred.
        pend_d       = pend_q;
        disp_d       = disp_q;
        pend_valid_d = pend_valid_q;

        // The swap consumes the pre-edge pending contents; a load in the same
        // cycle then becomes the next pending frame.
        if (swap_now) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end
        if (fb_load_i) begin
            pend_d       = fb_in_i;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: both buffers are cleared on reset so the first frame after
            // reset is blank; this keeps them in flops rather than RAM.
            pend_q       <= '0;
            disp_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // The first column of row 0 is read in the swap cycle itself, before
    // disp_q has been written, so the incoming frame is forwarded here.
    assign frame      = swap_now ? pend_q : disp_q;
    assign row_data_o = frame[drow];

endmodule

// File: rtl/dotmatrix_scanner.sv
// ---------------------------------------------------------------------------
// dotmatrix_scanner
//
// Scans a ROWS x COLS LED matrix. Each row is 2^TW shift slots of two clocks
// (setup, strobe). Slots 0..COLS-1 shift the column bits, slot COLS latches
// them, and the slots after that are the lit window, gated by PWM. The row
// register receives a walking zero clocked once per row.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset
//   bus (slave)  bitmap bus in, panel drive lines out (see dotmatrix_if)
//
// All panel outputs are registered and reflect the counter state of the
// previous cycle.
// ---------------------------------------------------------------------------
module dotmatrix_scanner
    import dotmatrix_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int TW      = DEF_TW,
    parameter int BW      = DEF_BW,
    parameter int ROW_FIX = DEF_ROW_FIX
) (
    input  logic       clk,
    input  logic       reset,
    dotmatrix_if.slave bus
);

    localparam int              RW       = $clog2(ROWS);
    localparam logic [TW-1:0]   SLOT_COL = TW'(COLS);
    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

    // Scan counters
    phase_e          phase_q, phase_d;
    logic [TW-1:0]   slot_q,  slot_d;
    logic [RW-1:0]   row_q,   row_d;
    logic [BW-1:0]   bright_q, bright_d;

    // Output registers
    logic            rclk_q, rclk_d;
    logic            rsdi_q, rsdi_d;
    logic            oeb_q,  oeb_d;
    logic            csdi_q, csdi_d;
    logic            cclk_q, cclk_d;
    logic            le_q,   le_d;
    logic            frame_start_q, frame_start_d;

    logic            swap_pt;
    logic [COLS-1:0] row_data;
    logic [2**TW-1:0] row_pad;
    logic            lit_window;

    // Frame swap point: first setup cycle of the frame.
    assign swap_pt = (phase_q == PH_SETUP) && (slot_q == '0) && (row_q == '0);

    dotmatrix_framebuf #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .ROW_FIX (ROW_FIX)
    ) u_framebuf (
        .clk        (clk),
        .reset      (reset),
        .fb_in_i    (bus.fb_in),
        .fb_load_i  (bus.fb_load),
        .swap_i     (swap_pt),
        .row_i      (row_q),
        .row_data_o (row_data)
    );

    // Zero-extending the row to one bit per slot makes slots >= COLS shift 0
    // without a separate range check.
    assign row_pad = (2**TW)'(row_data);

    // Blanking: the panel stays dark while columns shift and latch, then is
    // lit only for the part of the row allowed by the brightness setting.
    assign lit_window = (slot_q > SLOT_COL)
                     && pwm_on(32'(slot_q[TW-1 -: BW]), 32'(bright_q));

    always_comb begin
        phase_d       = (phase_q == PH_SETUP) ? PH_STROBE : PH_SETUP;
        slot_d        = slot_q;
        row_d         = row_q;
        bright_d      = bright_q;

        rclk_d        = 1'b0;
        cclk_d        = 1'b0;
        le_d          = 1'b0;
        rsdi_d        = rsdi_q;
        csdi_d        = csdi_q;
        oeb_d         = !lit_window;
        frame_start_d = swap_pt;

        if (phase_q == PH_SETUP) begin
            // Data changes only in setup so it is stable across the strobe.
            rsdi_d = !((row_q == '0) && (slot_q == '0));
            csdi_d = row_pad[slot_q];
            if (slot_q == '0) begin
                bright_d = bus.brightness;
            end
        end else begin
            rclk_d = (slot_q == '0);
            cclk_d = (slot_q < SLOT_COL);
            le_d   = (slot_q == SLOT_COL);
            slot_d = slot_q + TW'(1);
            if (slot_q == '1) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= PH_SETUP;
            slot_q        <= '0;
            row_q         <= '0;
            bright_q      <= '0;
            rclk_q        <= 1'b0;
            rsdi_q        <= 1'b0;
            oeb_q         <= 1'b1;
            csdi_q        <= 1'b0;
            cclk_q        <= 1'b0;
            le_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            slot_q        <= slot_d;
            row_q         <= row_d;
            bright_q      <= bright_d;
            rclk_q        <= rclk_d;
            rsdi_q        <= rsdi_d;
            oeb_q         <= oeb_d;
            csdi_q        <= csdi_d;
            cclk_q        <= cclk_d;
            le_q          <= le_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.rclk        = rclk_q;
    assign bus.rsdi        = rsdi_q;
    assign bus.oeb         = oeb_q;
    assign bus.csdi        = csdi_q;
    assign bus.cclk        = cclk_q;
    assign bus.le          = le_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_dotmatrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_dotmatrix_scanner
//
// Drives two scanners from one bitmap bus: dut0 with straight rows, dut1 with
// the row-pair swap. At each frame boundary the expected column bits of the
// whole frame are pushed into one queue per DUT; they are popped on every
// cclk pulse. Timing of the control lines is checked every cycle against the
// scan position derived from the cycle count since reset release.
// ---------------------------------------------------------------------------
module tb_dotmatrix_scanner;
    import dotmatrix_pkg::*;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int TW   = 6;
    localparam int BW   = 4;
    localparam int NPIX = ROWS * COLS;
    localparam int CPR  = 2 ** (TW + 1);
    localparam int CPF  = ROWS * CPR;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dotmatrix_if #(.ROWS(ROWS), .COLS(COLS), .BW(BW)) bus0 ();
    dotmatrix_if #(.ROWS(ROWS), .COLS(COLS), .BW(BW)) bus1 ();

    assign bus1.fb_in      = bus0.fb_in;
    assign bus1.fb_load    = bus0.fb_load;
    assign bus1.brightness = bus0.brightness;

    dotmatrix_scanner #(.ROWS(ROWS), .COLS(COLS), .TW(TW), .BW(BW), .ROW_FIX(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dotmatrix_scanner #(.ROWS(ROWS), .COLS(COLS), .TW(TW), .BW(BW), .ROW_FIX(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;        // edges since reset release = scan state consumed

    // Reference frame store and brightness seen by the current row
    logic [NPIX-1:0] m_disp, m_pend;
    bit              m_pv;
    int              bm;

    // Scoreboards: expected csdi bit at each cclk pulse
    bit q0[$];
    bit q1[$];

    int cnt_cclk, cnt_le, cnt_rclk, cnt_oeb;
    int last_row_oeb;

    logic [NPIX-1:0] pat_pix, pat_a, pat_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at t=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int oeb_row_cycles(input int b);
        int n = 0;
        for (int s = COLS + 1; s < 2 ** TW; s++) begin
            if ((s >> (TW - BW)) < b) n += 2;
        end
        return n;
    endfunction

    task automatic clear_model();
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
        bm     = 0;
        q0.delete();
        q1.delete();
        cnt_cclk = 0; cnt_le = 0; cnt_rclk = 0; cnt_oeb = 0;
        cyc = 0;
    endtask

    // Hold reset for n edges, checking the reset values after each edge.
    task automatic hold_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_rclk", bus0.rclk, 0);
            check("rst_rsdi", bus0.rsdi, 0);
            check("rst_cclk", bus0.cclk, 0);
            check("rst_csdi", bus0.csdi, 0);
            check("rst_le",   bus0.le,   0);
            check("rst_oeb",  bus0.oeb,  1);
            check("rst_fs",   bus0.frame_start, 0);
        end
        clear_model();
        reset = 1'b0;
    endtask

    // One clock: update the reference at the edge, then check the outputs
    // produced from scan state t.
    task automatic step();
        int  t, ph, sl, rw;
        bit  exp_oeb;
        bit  b;
        t  = cyc;
        ph = t % 2;
        sl = (t / 2) % (2 ** TW);
        rw = (t / CPR) % ROWS;

        if (t % CPF == 0) begin
            check("sb0_drained", q0.size(), 0);
            check("sb1_drained", q1.size(), 0);
            if (m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    q0.push_back(m_disp[pixel_index(r, c, COLS)]);
                    q1.push_back(m_disp[pixel_index(r ^ 1, c, COLS)]);
                end
            end
        end
        if (bus0.fb_load) begin
            m_pend = bus0.fb_in;
            m_pv   = 1'b1;
        end
        exp_oeb = !((sl > COLS) && ((sl >> (TW - BW)) < bm));
        if (t % CPR == 0) bm = int'(bus0.brightness);

        @(posedge clk);
        #1;
        cyc++;

        check("frame_start", bus0.frame_start, (t % CPF) == 0);
        check("rclk", bus0.rclk, (ph == 1) && (sl == 0));
        check("cclk", bus0.cclk, (ph == 1) && (sl < COLS));
        check("le",   bus0.le,   (ph == 1) && (sl == COLS));
        check("rsdi", bus0.rsdi, !((rw == 0) && (sl == 0)));
        check("oeb",  bus0.oeb,  exp_oeb);
        if (sl >= COLS) check("csdi_idle", bus0.csdi, 0);

        if (bus0.cclk) begin
            check("sb0_nonempty", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                b = q0.pop_front();
                check("csdi_straight", bus0.csdi, b);
            end
        end
        if (bus1.cclk) begin
            check("sb1_nonempty", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                b = q1.pop_front();
                check("csdi_rowfix", bus1.csdi, b);
            end
        end

        cnt_cclk += int'(bus0.cclk);
        cnt_le   += int'(bus0.le);
        cnt_rclk += int'(bus0.rclk);
        cnt_oeb  += int'(!bus0.oeb);
        if (t % CPR == CPR - 1) begin
            check("row_cclk_count", cnt_cclk, COLS);
            check("row_le_count",   cnt_le,   1);
            check("row_rclk_count", cnt_rclk, 1);
            check("row_oeb_count",  cnt_oeb,  oeb_row_cycles(bm));
            last_row_oeb = cnt_oeb;
            cnt_cclk = 0; cnt_le = 0; cnt_rclk = 0; cnt_oeb = 0;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic load(input logic [NPIX-1:0] v);
        bus0.fb_in   = v;
        bus0.fb_load = 1'b1;
        step();
        bus0.fb_load = 1'b0;
    endtask

    initial begin
        bus0.fb_in      = '0;
        bus0.fb_load    = 1'b0;
        bus0.brightness = '0;
        last_row_oeb    = -1;

        pat_pix = '0;
        pat_pix[pixel_index(3, 5, COLS)] = 1'b1;
        for (int i = 0; i < NPIX; i += 32) pat_a[i +: 32] = $urandom();
        pat_b = ~pat_a;

        // Reset, then the first outputs after release
        hold_reset(5);
        step();
        check("first_frame_start", bus0.frame_start, 1);
        check("first_rsdi",        bus0.rsdi,        0);
        step();
        check("first_rclk", bus0.rclk, 1);
        check("first_cclk", bus0.cclk, 1);
        check("first_rsdi_held", bus0.rsdi, 0);

        // Frame 0: blank, brightness 0; load the single pixel (3,5)
        run_to(100);
        load(pat_pix);
        run_to(CPR);
        check("bright0_row_oeb", last_row_oeb, 0);

        // Frame 1 shows the pixel; brightness 8, changed to 15 mid row 3
        run_to(CPF - 10);
        bus0.brightness = 4'd8;
        run_to(CPF + 3 * CPR);
        check("bright8_row_oeb", last_row_oeb, 30);
        run_to(CPF + 3 * CPR + 40);
        bus0.brightness = 4'd15;
        run_to(CPF + 4 * CPR);
        check("bright_midrow_row_oeb", last_row_oeb, 30);
        run_to(CPF + 5 * CPR);
        check("bright15_row_oeb", last_row_oeb, 86);

        // Frame 2: pattern A loaded mid-frame, frame keeps showing the pixel
        run_to(2 * CPF + 500);
        load(pat_a);

        // Frame 3 boundary: B loaded in the swap cycle; A shown, then B
        run_to(3 * CPF);
        check("swap_cycle_frame_start_pending", cyc, 3 * CPF);
        load(pat_b);

        // Frame 4 shows B; reset in the middle of row 7
        run_to(4 * CPF + 7 * CPR + 30);
        hold_reset(3);

        // First frame after reset must be blank
        run_to(CPF + 4);
        check("post_reset_pend", m_pv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
